sc_io_port: RTL and testbench

- Memory-mapped I/O responder on the CPU data bus. It is the device end of the switch/seven-segment interface that the top-level simulation drives and observes.
- Switch input path: synchronizes and debounces sw[9:0] and presents it as two read-only input ports.
- Display path: captures CPU writes to three output ports and converts each to two decimal digits with a sequential binary-to-BCD engine. The digits drive hex0..hex5.
- Sits beside the data memory; the top level routes wmem/aluout/data to it and muxes rdata into the load path.

---
 rtl/sc_io_port.sv | 212 +++++++++++++++++++++
 tb/tb_sc_io_port.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_port.sv
// Memory-mapped switch / seven-segment responder: debounced switch input ports and
// three output ports rendered as two decimal digits by a serial double-dabble engine.
module sc_io_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 20
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   input  logic [9:0]  sw,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [6:0]       SEG_DASH = 7'b0111111;
   localparam logic [6:0]       SEG_ZERO = 7'b1000000;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_DASH;
      endcase
   endfunction

   logic [9:0]       sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, sw_db_q, sw_db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      out_port_q [3];
   logic [31:0]      out_port_d [3];
   logic [6:0]       hex_q [6];
   logic [6:0]       hex_d [6];
   logic [2:0]       pending_q, pending_d;
   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [31:0]      val_q, val_d;
   logic [6:0]       shift_q, shift_d;
   logic [7:0]       bcd_q, bcd_d;
   logic [2:0]       step_q, step_d;

   logic       out_hit, in_hit;
   logic [1:0] port_idx;
   logic       unused_addr;

   assign port_idx    = addr[3:2];
   assign out_hit     = (addr[7:6] == 2'b10) && (addr[5:4] == 2'b00) && (addr[3:2] != 2'b11);
   assign in_hit      = (addr[7:6] == 2'b11) && (addr[5:3] == 3'b000);
   assign unused_addr = ^{addr[31:8], addr[1:0]};

   always_comb begin
      rdata = '0;
      if (out_hit) begin
         rdata = out_port_q[port_idx];
      end else if (in_hit) begin
         rdata = addr[2] ? {27'b0, sw_db_q[9:5]} : {27'b0, sw_db_q[4:0]};
      end
   end

   // Any change of the synchronized value restarts the stability count.
   always_comb begin
      sync1_d = sw;
      sync2_d = sync1_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      sw_db_d = sw_db_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
         sw_db_d = cand_q;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   logic [2:0]  pend_set, pend_clr;
   logic [1:0]  pick;
   logic [7:0]  adj;
   logic [14:0] dd;
   logic [6:0]  tens, ones;

   always_comb begin
      state_d    = state_q;
      out_port_d = out_port_q;
      hex_d      = hex_q;
      sel_d      = sel_q;
      val_d      = val_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      step_d     = step_q;
      pend_set   = '0;
      pend_clr   = '0;
      pick       = '0;
      adj        = '0;
      dd         = '0;
      tens       = SEG_DASH;
      ones       = SEG_DASH;

      for (int unsigned i = 0; i < 3; i++) begin
         if (we && out_hit && (port_idx == i[1:0])) begin
            out_port_d[i] = wdata;
            pend_set[i]   = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               if (pending_q[0]) begin
                  pick = 2'd0; pend_clr = 3'b001;
               end else if (pending_q[1]) begin
                  pick = 2'd1; pend_clr = 3'b010;
               end else begin
                  pick = 2'd2; pend_clr = 3'b100;
               end
               sel_d   = pick;
               val_d   = out_port_q[pick];
               shift_d = out_port_q[pick][6:0];
               bcd_d   = '0;
               step_d  = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            adj = bcd_q;
            if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
            if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
            dd      = {adj, shift_q} << 1;
            bcd_d   = dd[14:7];
            shift_d = dd[6:0];
            step_d  = step_q + 1'b1;
            if (step_q == 3'd6) state_d = S_DONE;
         end
         S_DONE: begin
            if (val_q <= 32'd99) begin
               tens = seg7(bcd_q[7:4]);
               ones = seg7(bcd_q[3:0]);
            end
            case (sel_q)
               2'd0:    begin hex_d[1] = tens; hex_d[0] = ones; end
               2'd1:    begin hex_d[3] = tens; hex_d[2] = ones; end
               default: begin hex_d[5] = tens; hex_d[4] = ones; end
            endcase
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A store landing on the selection edge re-arms its port.
      pending_d = (pending_q & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         sw_db_q   <= '0;
         cnt_q     <= '0;
         pending_q <= '0;
         state_q   <= S_IDLE;
         sel_q     <= '0;
         val_q     <= '0;
         shift_q   <= '0;
         bcd_q     <= '0;
         step_q    <= '0;
         for (int unsigned i = 0; i < 3; i++) out_port_q[i] <= '0;
         for (int unsigned i = 0; i < 6; i++) hex_q[i] <= SEG_ZERO;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         cand_q     <= cand_d;
         sw_db_q    <= sw_db_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
         sel_q      <= sel_d;
         val_q      <= val_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         step_q     <= step_d;
         out_port_q <= out_port_d;
         hex_q      <= hex_d;
      end
   end

   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];
   assign busy = (state_q != S_IDLE) || (|pending_q);

endmodule

// File: tb/tb_sc_io_port.sv
// Self-checking bench for sc_io_port: directed scenarios plus randomized store bursts,
// checked against a value-level model of ports, switches and decimal display.
module tb_sc_io_port;
   localparam int unsigned DEB = 4;

   logic        clock  = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] addr   = '0;
   logic [31:0] wdata  = '0;
   logic        we     = 1'b0;
   logic [9:0]  sw     = '0;
   logic [31:0] rdata;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        busy;
   logic [6:0]  hex_obs [6];

   int checks = 0;
   int errors = 0;

   logic [31:0] port_model [3];
   logic [9:0]  sw_model;

   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   localparam logic [6:0] DASH = 7'b0111111;

   sc_io_port #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
      .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
      .sw(sw), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
      .busy(busy)
   );

   assign hex_obs[0] = hex0;
   assign hex_obs[1] = hex1;
   assign hex_obs[2] = hex2;
   assign hex_obs[3] = hex3;
   assign hex_obs[4] = hex4;
   assign hex_obs[5] = hex5;

   always #5 clock = ~clock;

   // Expected {tens, ones} segment pair for a port value.
   function automatic logic [13:0] exp_pair(input logic [31:0] v);
      if (v > 32'd99) exp_pair = {DASH, DASH};
      else exp_pair = {seg_tbl[v / 10], seg_tbl[v % 10]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300 && busy !== 1'b0; k++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b required 0 within 300 cycles", busy);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      sw     = '0;
      repeat (2) tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (hex_obs[i] !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_hex%0d: got %b required 1000000", i, hex_obs[i]);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b required 0", busy);
      end
      addr = 32'h80;
      #1;
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_port0: got %0d required 0", rdata);
      end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) port_model[i] = '0;
      sw_model = '0;
   endtask

   task automatic test_switch_debounce();
      sw = 10'b0000110000;
      repeat (DEB - 1) tick();
      addr = 32'hC0; #1;
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL sw_early_in0: got %0d required 0", rdata);
      end
      addr = 32'hC4; #1;
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL sw_early_in1: got %0d required 0", rdata);
      end
      repeat (4) tick();
      sw_model = sw;
      addr = 32'hC0; #1;
      checks++;
      if (rdata !== {27'b0, sw_model[4:0]}) begin
         errors++;
         $display("FAIL sw_in0: got %0d required %0d", rdata, sw_model[4:0]);
      end
      addr = 32'hC4; #1;
      checks++;
      if (rdata !== {27'b0, sw_model[9:5]}) begin
         errors++;
         $display("FAIL sw_in1: got %0d required %0d", rdata, sw_model[9:5]);
      end
   endtask

   task automatic test_glitch();
      sw = sw_model ^ 10'b0000000001;
      repeat (2) tick();
      sw = sw_model;
      for (int k = 0; k < 12; k++) begin
         tick();
         addr = 32'hC0; #1;
         checks++;
         if (rdata !== {27'b0, sw_model[4:0]}) begin
            errors++;
            $display("FAIL glitch_in0: cycle %0d got %0d required %0d", k, rdata, sw_model[4:0]);
         end
      end
   endtask

   task automatic test_switch_random();
      logic [9:0] v;
      for (int n = 0; n < 4; n++) begin
         v  = 10'($urandom_range(0, 1023));
         sw = v;
         repeat (DEB - 1) tick();
         addr = 32'hC4; #1;
         checks++;
         if (rdata !== {27'b0, sw_model[9:5]}) begin
            errors++;
            $display("FAIL swr_hold_in1: got %0d required %0d", rdata, sw_model[9:5]);
         end
         repeat (4) tick();
         sw_model = v;
         addr = 32'hC0; #1;
         checks++;
         if (rdata !== {27'b0, sw_model[4:0]}) begin
            errors++;
            $display("FAIL swr_in0: got %0d required %0d", rdata, sw_model[4:0]);
         end
         addr = 32'hC4; #1;
         checks++;
         if (rdata !== {27'b0, sw_model[9:5]}) begin
            errors++;
            $display("FAIL swr_in1: got %0d required %0d", rdata, sw_model[9:5]);
         end
      end
   endtask

   task automatic test_write_latency();
      logic [13:0] old_pair, new_pair;
      int          busy_hi;
      old_pair = exp_pair(port_model[0]);
      do_write(32'h80, 32'd42);
      port_model[0] = 32'd42;
      new_pair = exp_pair(port_model[0]);
      busy_hi = (busy === 1'b1) ? 1 : 0;
      repeat (8) begin
         tick();
         if (busy === 1'b1) busy_hi++;
      end
      checks++;
      if ({hex1, hex0} !== old_pair) begin
         errors++;
         $display("FAIL lat_early: hex1:hex0 got %b required %b at T+8", {hex1, hex0}, old_pair);
      end
      tick();
      checks++;
      if ({hex1, hex0} !== new_pair) begin
         errors++;
         $display("FAIL lat_t9: hex1:hex0 got %b required %b", {hex1, hex0}, new_pair);
      end
      checks++;
      if (busy_hi != 9 || busy !== 1'b0) begin
         errors++;
         $display("FAIL lat_busy: high cycles %0d (required 9), busy now %b (required 0)", busy_hi, busy);
      end
      addr = 32'h80; #1;
      checks++;
      if (rdata !== port_model[0]) begin
         errors++;
         $display("FAIL lat_readback: got %0d required %0d", rdata, port_model[0]);
      end
   endtask

   task automatic test_range();
      do_write(32'h84, 32'd150);
      port_model[1] = 32'd150;
      repeat (9) tick();
      checks++;
      if ({hex3, hex2} !== {DASH, DASH}) begin
         errors++;
         $display("FAIL range_dash: hex3:hex2 got %b required %b", {hex3, hex2}, {DASH, DASH});
      end
      checks++;
      if ({hex1, hex0} !== exp_pair(port_model[0])) begin
         errors++;
         $display("FAIL range_other: hex1:hex0 got %b required %b", {hex1, hex0}, exp_pair(port_model[0]));
      end
   endtask

   task automatic test_back_to_back();
      do_write(32'h88, 32'd7);
      do_write(32'h80, 32'd99);
      do_write(32'h84, 32'd5);
      port_model[2] = 32'd7;
      port_model[0] = 32'd99;
      port_model[1] = 32'd5;
      wait_idle();
      for (int p = 0; p < 3; p++) begin
         checks++;
         if ({hex_obs[2*p+1], hex_obs[2*p]} !== exp_pair(port_model[p])) begin
            errors++;
            $display("FAIL b2b_pair%0d: got %b required %b", p, {hex_obs[2*p+1], hex_obs[2*p]}, exp_pair(port_model[p]));
         end
      end
   endtask

   task automatic test_rewrite();
      do_write(32'h80, 32'd12);
      repeat (2) tick();
      do_write(32'h80, 32'd34);
      repeat (6) tick();
      checks++;
      if ({hex1, hex0} !== exp_pair(32'd12)) begin
         errors++;
         $display("FAIL rewrite_transient: got %b required %b", {hex1, hex0}, exp_pair(32'd12));
      end
      port_model[0] = 32'd34;
      wait_idle();
      checks++;
      if ({hex1, hex0} !== exp_pair(port_model[0])) begin
         errors++;
         $display("FAIL rewrite_final: got %b required %b", {hex1, hex0}, exp_pair(port_model[0]));
      end
   endtask

   task automatic test_reset_mid_shift();
      do_write(32'h84, 32'd55);
      repeat (3) tick();
      resetn = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (hex_obs[i] !== 7'b1000000) begin
            errors++;
            $display("FAIL midrst_hex%0d: got %b required 1000000", i, hex_obs[i]);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_busy: got %b required 0", busy);
      end
      for (int i = 0; i < 3; i++) port_model[i] = '0;
      repeat (2) tick();
      resetn = 1'b1;
      repeat (12) tick();
      checks++;
      if (busy !== 1'b0 || {hex3, hex2} !== exp_pair(32'd0)) begin
         errors++;
         $display("FAIL midrst_after: busy %b hex3:hex2 %b required 0 and %b", busy, {hex3, hex2}, exp_pair(32'd0));
      end
      addr = 32'h84; #1;
      checks++;
      if (rdata !== port_model[1]) begin
         errors++;
         $display("FAIL midrst_port1: got %0d required %0d", rdata, port_model[1]);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, a, v;
      logic [7:0]  lo;
      int          p, nb;
      for (int it = 0; it < 20; it++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            r = $urandom();
            v = ($urandom_range(0, 2) == 0) ? $urandom() : 32'($urandom_range(0, 120));
            if ($urandom_range(0, 4) == 0) begin
               case ($urandom_range(0, 2))
                  0:       lo = {2'b00, r[5:0]};
                  1:       lo = {2'b10, 4'($urandom_range(3, 15)), r[1:0]};
                  default: lo = {2'b11, r[5:0]};
               endcase
               a = {r[31:8], lo};
            end else begin
               p = $urandom_range(0, 2);
               a = {r[31:8], 2'b10, 4'(p), r[1:0]};
               port_model[p] = v;
            end
            do_write(a, v);
         end
         wait_idle();
         for (int q = 0; q < 3; q++) begin
            checks++;
            if ({hex_obs[2*q+1], hex_obs[2*q]} !== exp_pair(port_model[q])) begin
               errors++;
               $display("FAIL rnd_pair%0d: iter %0d got %b required %b", q, it, {hex_obs[2*q+1], hex_obs[2*q]}, exp_pair(port_model[q]));
            end
            r = $urandom();
            addr = {r[31:8], 2'b10, 4'(q), r[1:0]}; #1;
            checks++;
            if (rdata !== port_model[q]) begin
               errors++;
               $display("FAIL rnd_read%0d: iter %0d got %0h required %0h", q, it, rdata, port_model[q]);
            end
         end
         addr = 32'h8C; #1;
         checks++;
         if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL rnd_unmapped: got %0h required 0", rdata);
         end
         addr = 32'hC0; #1;
         checks++;
         if (rdata !== {27'b0, sw_model[4:0]}) begin
            errors++;
            $display("FAIL rnd_in0: got %0d required %0d", rdata, sw_model[4:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_switch_debounce();
      test_glitch();
      test_switch_random();
      test_write_latency();
      test_range();
      test_back_to_back();
      test_rewrite();
      test_reset_mid_shift();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
